pdp11_operand_writer: RTL and testbench

//  Destination write-back unit for the PDP-11 core: stores a result word/byte to the operand selected by
//  a 3-bit addressing mode + 3-bit register field (modes 0-7). Write-side counterpart of operand fetch.

---
 rtl/pdp11_operand_writer.sv | 196 +++++++++++++++++++
 tb/tb_pdp11_operand_writer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdp11_operand_writer.sv
// Destination write-back for the PDP-11 core: stores a word/byte to the operand named by
// mode/reg_sel, performing autoinc/autodec and the PC advance over index words.
module pdp11_operand_writer #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [2:0]        mode,
   input  logic [2:0]        reg_sel,
   input  logic              byte_op,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [2:0]        reg_rd_sel,
   input  logic [DATA_W-1:0] reg_rd_data,
   output logic              reg_wr_en,
   output logic [2:0]        reg_wr_sel,
   output logic [DATA_W-1:0] reg_wr_data,
   output logic              reg_wr_byte,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_byte,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [2:0] {StIdle, StIdx, StAddr, StPtr, StWr, StDone} state_e;

   state_e            state_q, state_d;
   logic [2:0]        mode_q, mode_d;
   logic [2:0]        rn_q, rn_d;
   logic              byte_q, byte_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] x_q, x_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              err_q, err_d;

   logic [DATA_W-1:0] inc;
   logic [DATA_W-1:0] tgt;
   logic              addr_wr_en;
   logic [DATA_W-1:0] addr_wr_val;
   logic              ptr_mode;

   // Index word is fetched through R7 while in StIdx; otherwise Rn is read in StAddr.
   assign reg_rd_sel = (state_q == StIdx)  ? 3'd7 :
                       (state_q == StAddr) ? rn_q : 3'd0;

   assign busy      = (state_q != StIdle);
   assign done      = (state_q == StDone);
   assign err       = (state_q == StDone) && err_q;
   assign mem_req   = ((state_q == StIdx) && !reg_rd_data[0]) ||
                      (state_q == StPtr) || (state_q == StWr);
   assign mem_we    = (state_q == StWr);
   assign mem_byte  = (state_q == StWr) && byte_q;
   assign mem_wdata = (state_q != StWr) ? '0 :
                      byte_q ? DATA_W'({2{wdata_q[7:0]}}) : wdata_q;
   assign mem_addr  = (state_q == StIdx) ? ADDR_W'(reg_rd_data) :
                      ((state_q == StPtr) || (state_q == StWr)) ? addr_q : '0;

   assign ptr_mode = (mode_q == 3'd3) || (mode_q == 3'd5) || (mode_q == 3'd7);

   // SP and PC always step by 2 so they stay word aligned.
   assign inc = (byte_q && (rn_q < 3'd6)) ? DATA_W'(1) : DATA_W'(2);

   always_comb begin
      tgt         = reg_rd_data;
      addr_wr_en  = 1'b0;
      addr_wr_val = reg_rd_data;
      unique case (mode_q)
         3'd0: begin
            addr_wr_en  = 1'b1;
            addr_wr_val = wdata_q;
         end
         3'd1: tgt = reg_rd_data;
         3'd2: begin
            addr_wr_en  = 1'b1;
            addr_wr_val = reg_rd_data + inc;
         end
         3'd3: begin
            addr_wr_en  = 1'b1;
            addr_wr_val = reg_rd_data + DATA_W'(2);
         end
         3'd4: begin
            tgt         = reg_rd_data - inc;
            addr_wr_en  = 1'b1;
            addr_wr_val = reg_rd_data - inc;
         end
         3'd5: begin
            tgt         = reg_rd_data - DATA_W'(2);
            addr_wr_en  = 1'b1;
            addr_wr_val = reg_rd_data - DATA_W'(2);
         end
         3'd6, 3'd7: tgt = reg_rd_data + x_q;
         default: tgt = reg_rd_data;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      rn_d        = rn_q;
      byte_d      = byte_q;
      wdata_d     = wdata_q;
      x_d         = x_q;
      addr_d      = addr_q;
      err_d       = err_q;
      reg_wr_en   = 1'b0;
      reg_wr_sel  = 3'd0;
      reg_wr_data = '0;
      reg_wr_byte = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               mode_d  = mode;
               rn_d    = reg_sel;
               byte_d  = byte_op;
               wdata_d = wdata;
               err_d   = 1'b0;
               state_d = (mode[2:1] == 2'b11) ? StIdx : StAddr;
            end
         end
         StIdx: begin
            if (reg_rd_data[0]) begin
               err_d   = 1'b1;
               state_d = StDone;
            end else if (mem_ack) begin
               x_d         = mem_rdata;
               reg_wr_en   = 1'b1;
               reg_wr_sel  = 3'd7;
               reg_wr_data = reg_rd_data + DATA_W'(2);
               state_d     = StAddr;
            end
         end
         StAddr: begin
            reg_wr_en   = addr_wr_en;
            reg_wr_sel  = rn_q;
            reg_wr_data = addr_wr_val;
            reg_wr_byte = (mode_q == 3'd0) && byte_q;
            if (mode_q == 3'd0) begin
               state_d = StDone;
            end else if (tgt[0] && (ptr_mode || !byte_q)) begin
               err_d   = 1'b1;
               state_d = StDone;
            end else begin
               addr_d  = ADDR_W'(tgt);
               state_d = ptr_mode ? StPtr : StWr;
            end
         end
         StPtr: begin
            if (mem_ack) begin
               if (mem_rdata[0] && !byte_q) begin
                  err_d   = 1'b1;
                  state_d = StDone;
               end else begin
                  addr_d  = ADDR_W'(mem_rdata);
                  state_d = StWr;
               end
            end
         end
         StWr: begin
            if (mem_ack) state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         mode_q  <= 3'd0;
         rn_q    <= 3'd0;
         byte_q  <= 1'b0;
         wdata_q <= '0;
         x_q     <= '0;
         addr_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         rn_q    <= rn_d;
         byte_q  <= byte_d;
         wdata_q <= wdata_d;
         x_q     <= x_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_pdp11_operand_writer.sv
// Directed bench for pdp11_operand_writer with a register-file and memory model.
module tb_pdp11_operand_writer;

   logic        clk = 1'b0;
   logic        rst_n, start, byte_op;
   logic [2:0]  mode, reg_sel;
   logic [15:0] wdata;
   logic        busy, done, err;
   logic [2:0]  reg_rd_sel, reg_wr_sel;
   logic [15:0] reg_rd_data, reg_wr_data;
   logic        reg_wr_en, reg_wr_byte;
   logic        mem_req, mem_we, mem_byte, mem_ack;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;

   logic [15:0] regs [8];
   logic [15:0] mem  [32768];

   logic        ld_reg = 1'b0;
   logic [2:0]  ld_ri = 3'd0;
   logic [15:0] ld_rv = 16'h0;
   logic        ld_mem = 1'b0;
   logic [14:0] ld_mi = 15'h0;
   logic [15:0] ld_mv = 16'h0;

   int unsigned ack_delay = 0;
   int unsigned wcnt = 0;
   int          n_req_cyc = 0;
   int          n_mem_wr = 0;
   logic [15:0] last_md = 16'h0;
   logic        last_mb = 1'b0;
   logic        last_rwb = 1'b0;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pdp11_operand_writer #(.ADDR_W(16), .DATA_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .reg_sel(reg_sel),
      .byte_op(byte_op), .wdata(wdata), .busy(busy), .done(done), .err(err),
      .reg_rd_sel(reg_rd_sel), .reg_rd_data(reg_rd_data), .reg_wr_en(reg_wr_en),
      .reg_wr_sel(reg_wr_sel), .reg_wr_data(reg_wr_data), .reg_wr_byte(reg_wr_byte),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_byte(mem_byte),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   assign reg_rd_data = regs[reg_rd_sel];
   assign mem_rdata   = mem[mem_addr[15:1]];
   assign mem_ack     = mem_req && (wcnt >= ack_delay);

   always @(posedge clk) begin
      if (ld_reg) regs[ld_ri] <= ld_rv;
      else if (reg_wr_en) begin
         if (reg_wr_byte) regs[reg_wr_sel][7:0] <= reg_wr_data[7:0];
         else regs[reg_wr_sel] <= reg_wr_data;
         last_rwb <= reg_wr_byte;
      end
      if (ld_mem) mem[ld_mi] <= ld_mv;
      else if (mem_req && mem_ack && mem_we) begin
         if (!mem_byte) mem[mem_addr[15:1]] <= mem_wdata;
         else if (mem_addr[0]) mem[mem_addr[15:1]][15:8] <= mem_wdata[15:8];
         else mem[mem_addr[15:1]][7:0] <= mem_wdata[7:0];
         n_mem_wr <= n_mem_wr + 1;
         last_md  <= mem_wdata;
         last_mb  <= mem_byte;
      end
      if (mem_req) n_req_cyc <= n_req_cyc + 1;
      wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
   end

   task automatic set_reg(input logic [2:0] i, input logic [15:0] v);
      @(negedge clk);
      ld_reg = 1'b1; ld_ri = i; ld_rv = v;
      @(negedge clk);
      ld_reg = 1'b0;
   endtask

   task automatic set_mem(input logic [15:0] a, input logic [15:0] v);
      @(negedge clk);
      ld_mem = 1'b1; ld_mi = a[15:1]; ld_mv = v;
      @(negedge clk);
      ld_mem = 1'b0;
   endtask

   // Returns cycles from the accepting edge to the done cycle (999 if done never came).
   task automatic run_op(input logic [2:0] m, input logic [2:0] r, input logic b,
                         input logic [15:0] wd, output int lat, output logic e);
      logic got;
      got = 1'b0;
      lat = 0;
      e   = 1'b0;
      @(negedge clk);
      mode = m; reg_sel = r; byte_op = b; wdata = wd; start = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            got = 1'b1;
            e   = err;
            break;
         end
      end
      if (!got) lat = 999;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; mode = 3'd0; reg_sel = 3'd0; byte_op = 1'b0; wdata = 16'h0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if ({busy, done, err, mem_req, mem_we, mem_byte, reg_wr_en, reg_wr_byte} !== 8'h00) begin
         fails++;
         $display("FAIL reset_ctrl: got %b expected 00000000",
                  {busy, done, err, mem_req, mem_we, mem_byte, reg_wr_en, reg_wr_byte});
      end
      tests++;
      if ({mem_addr, mem_wdata, reg_wr_data} !== 48'h0) begin
         fails++;
         $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, reg_wr_data});
      end
      tests++;
      if (reg_rd_sel !== 3'd0) begin
         fails++;
         $display("FAIL reset_rdsel: got %0d expected 0", reg_rd_sel);
      end
   endtask

   task automatic test_mode0();
      int lat; logic e; int nreq;
      set_reg(3'd2, 16'h1234);
      nreq = n_req_cyc;
      run_op(3'd0, 3'd2, 1'b1, 16'hABCD, lat, e);
      tests++;
      if (regs[2] !== 16'h12CD) begin
         fails++; $display("FAIL m0_reg: got %h expected 12cd", regs[2]);
      end
      tests++;
      if (last_rwb !== 1'b1) begin
         fails++; $display("FAIL m0_wrbyte: got %b expected 1", last_rwb);
      end
      tests++;
      if (lat != 2 || e !== 1'b0) begin
         fails++; $display("FAIL m0_lat_err: got %0d/%b expected 2/0", lat, e);
      end
      tests++;
      if (n_req_cyc != nreq) begin
         fails++; $display("FAIL m0_nomem: got %0d req cycles expected 0", n_req_cyc - nreq);
      end
   endtask

   task automatic test_mode2();
      int lat; logic e;
      set_reg(3'd1, 16'h0100);
      set_mem(16'h0100, 16'h0000);
      run_op(3'd2, 3'd1, 1'b0, 16'h5555, lat, e);
      tests++;
      if (mem[16'h0080] !== 16'h5555 || regs[1] !== 16'h0102) begin
         fails++;
         $display("FAIL m2_word: got mem %h R1 %h expected 5555 0102", mem[16'h0080], regs[1]);
      end
      tests++;
      if (lat != 3 || e !== 1'b0) begin
         fails++; $display("FAIL m2_lat_err: got %0d/%b expected 3/0", lat, e);
      end
      set_reg(3'd6, 16'h0400);
      set_mem(16'h0400, 16'hAAAA);
      run_op(3'd2, 3'd6, 1'b1, 16'h0077, lat, e);
      tests++;
      if (regs[6] !== 16'h0402) begin
         fails++; $display("FAIL m2_sp_inc: got %h expected 0402", regs[6]);
      end
      tests++;
      if (mem[16'h0200] !== 16'hAA77 || lat != 3) begin
         fails++; $display("FAIL m2_sp_byte: got %h lat %0d expected aa77 lat 3", mem[16'h0200], lat);
      end
   endtask

   task automatic test_mode4();
      int lat; logic e;
      set_reg(3'd3, 16'h0200);
      set_mem(16'h01FE, 16'h1111);
      run_op(3'd4, 3'd3, 1'b1, 16'h00EE, lat, e);
      tests++;
      if (regs[3] !== 16'h01FF) begin
         fails++; $display("FAIL m4_reg: got %h expected 01ff", regs[3]);
      end
      tests++;
      if (mem[16'h00FF] !== 16'hEE11) begin
         fails++; $display("FAIL m4_mem: got %h expected ee11", mem[16'h00FF]);
      end
      tests++;
      if (last_md !== 16'hEEEE || last_mb !== 1'b1) begin
         fails++; $display("FAIL m4_wdata: got %h/%b expected eeee/1", last_md, last_mb);
      end
      tests++;
      if (lat != 3 || e !== 1'b0) begin
         fails++; $display("FAIL m4_lat_err: got %0d/%b expected 3/0", lat, e);
      end
   endtask

   task automatic test_mode6();
      int lat; logic e;
      set_reg(3'd5, 16'h0100);
      set_reg(3'd7, 16'h2000);
      set_mem(16'h2000, 16'h0004);
      run_op(3'd6, 3'd5, 1'b0, 16'hC0DE, lat, e);
      tests++;
      if (regs[7] !== 16'h2002 || mem[16'h0082] !== 16'hC0DE) begin
         fails++; $display("FAIL m6: got R7 %h mem %h expected 2002 c0de", regs[7], mem[16'h0082]);
      end
      tests++;
      if (lat != 4 || e !== 1'b0) begin
         fails++; $display("FAIL m6_lat_err: got %0d/%b expected 4/0", lat, e);
      end
   endtask

   task automatic test_mode7();
      int lat; logic e;
      set_reg(3'd7, 16'h1000);
      set_mem(16'h1000, 16'h0010);
      set_mem(16'h1012, 16'h0300);
      run_op(3'd7, 3'd7, 1'b0, 16'hBEEF, lat, e);
      tests++;
      if (regs[7] !== 16'h1002) begin
         fails++; $display("FAIL m7_pc: got %h expected 1002", regs[7]);
      end
      tests++;
      if (mem[16'h0180] !== 16'hBEEF) begin
         fails++; $display("FAIL m7_mem: got %h expected beef", mem[16'h0180]);
      end
      tests++;
      if (lat != 5 || e !== 1'b0) begin
         fails++; $display("FAIL m7_lat_err: got %0d/%b expected 5/0", lat, e);
      end
   endtask

   task automatic test_mode5();
      int lat; logic e;
      set_reg(3'd2, 16'h0304);
      set_mem(16'h0302, 16'h0600);
      run_op(3'd5, 3'd2, 1'b0, 16'h4242, lat, e);
      tests++;
      if (regs[2] !== 16'h0302 || mem[16'h0300] !== 16'h4242) begin
         fails++; $display("FAIL m5: got R2 %h mem %h expected 0302 4242", regs[2], mem[16'h0300]);
      end
      tests++;
      if (lat != 4 || e !== 1'b0) begin
         fails++; $display("FAIL m5_lat_err: got %0d/%b expected 4/0", lat, e);
      end
   endtask

   task automatic test_odd();
      int lat; logic e; int nreq;
      set_reg(3'd0, 16'h0101);
      nreq = n_req_cyc;
      run_op(3'd1, 3'd0, 1'b0, 16'h9999, lat, e);
      tests++;
      if (e !== 1'b1 || lat != 2) begin
         fails++; $display("FAIL odd_err: got %b lat %0d expected 1 lat 2", e, lat);
      end
      tests++;
      if (n_req_cyc != nreq) begin
         fails++; $display("FAIL odd_noreq: got %0d req cycles expected 0", n_req_cyc - nreq);
      end
   endtask

   task automatic test_wrap();
      int lat; logic e;
      set_reg(3'd4, 16'hFFFE);
      set_mem(16'hFFFE, 16'h0500);
      run_op(3'd3, 3'd4, 1'b0, 16'h7777, lat, e);
      tests++;
      if (regs[4] !== 16'h0000) begin
         fails++; $display("FAIL m3_wrap: got %h expected 0000", regs[4]);
      end
      tests++;
      if (mem[16'h0280] !== 16'h7777 || lat != 4 || e !== 1'b0) begin
         fails++;
         $display("FAIL m3_mem: got %h lat %0d err %b expected 7777 lat 4 err 0",
                  mem[16'h0280], lat, e);
      end
   endtask

   task automatic test_ack_delay();
      int lat; int bad; int bsy; logic got; logic cap_ok;
      logic [15:0] cap_a, cap_d;
      ack_delay = 3;
      set_reg(3'd0, 16'h0200);
      set_reg(3'd5, 16'h5A5A);
      lat = 0; bad = 0; got = 1'b0; cap_ok = 1'b0; cap_a = 16'h0; cap_d = 16'h0;
      @(negedge clk);
      mode = 3'd1; reg_sel = 3'd0; byte_op = 1'b0; wdata = 16'h1357; start = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         start = 1'b0;
         if (i == 2) begin
            mode = 3'd0; reg_sel = 3'd5; wdata = 16'hFFFF; start = 1'b1;
         end
         if (mem_req) begin
            if (!cap_ok) begin
               cap_a = mem_addr; cap_d = mem_wdata; cap_ok = 1'b1;
            end else if (mem_addr !== cap_a || mem_wdata !== cap_d || mem_we !== 1'b1) bad++;
         end
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      start = 1'b0;
      if (!got) lat = 999;
      bsy = 0;
      repeat (3) begin
         @(negedge clk);
         if (busy) bsy++;
      end
      ack_delay = 0;
      tests++;
      if (lat != 6) begin
         fails++; $display("FAIL delay_lat: got %0d expected 6", lat);
      end
      tests++;
      if (bad != 0 || cap_a !== 16'h0200 || cap_d !== 16'h1357) begin
         fails++;
         $display("FAIL delay_stable: got %0d changes addr %h data %h expected 0 0200 1357",
                  bad, cap_a, cap_d);
      end
      tests++;
      if (mem[16'h0100] !== 16'h1357) begin
         fails++; $display("FAIL delay_mem: got %h expected 1357", mem[16'h0100]);
      end
      tests++;
      if (regs[5] !== 16'h5A5A || bsy != 0) begin
         fails++;
         $display("FAIL busy_start_ignored: got R5 %h busy cycles %0d expected 5a5a 0",
                  regs[5], bsy);
      end
   endtask

   task automatic test_reset_mid();
      int lat; logic e; logic hit;
      ack_delay = 5;
      set_reg(3'd0, 16'h0240);
      set_mem(16'h0240, 16'h0000);
      hit = 1'b0;
      @(negedge clk);
      mode = 3'd1; reg_sel = 3'd0; byte_op = 1'b0; wdata = 16'h2468; start = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (mem_req && mem_we) begin
            hit = 1'b1;
            break;
         end
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      tests++;
      if (!hit || {mem_req, busy, done} !== 3'b000) begin
         fails++;
         $display("FAIL reset_mid: got reached %b req/busy/done %b expected 1 000",
                  hit, {mem_req, busy, done});
      end
      @(negedge clk);
      rst_n = 1'b1;
      ack_delay = 0;
      tests++;
      if (mem[16'h0120] !== 16'h0000) begin
         fails++; $display("FAIL reset_mid_nowrite: got %h expected 0000", mem[16'h0120]);
      end
      run_op(3'd0, 3'd3, 1'b0, 16'h3C3C, lat, e);
      tests++;
      if (regs[3] !== 16'h3C3C || lat != 2) begin
         fails++; $display("FAIL after_reset_op: got %h lat %0d expected 3c3c lat 2", regs[3], lat);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_mode0();
      test_mode2();
      test_mode4();
      test_mode6();
      test_mode7();
      test_mode5();
      test_odd();
      test_wrap();
      test_ack_delay();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
